// File: rtl/bp_perf_sample_ctrl_if.sv
// Snapshot stream channel: 64-bit words with valid/ready plus word-3 and final-snapshot markers.
interface bp_perf_sample_ctrl_if #(
    parameter int cnt_width_p = 64
);
    logic [cnt_width_p-1:0] data_o;
    logic                   v_o;
    logic                   ready_i;
    logic                   last_o;
    logic                   final_o;

    modport master (output data_o, output v_o, output last_o, output final_o, input ready_i);
    modport slave  (input data_o, input v_o, input last_o, input final_o, output ready_i);
endinterface

// File: rtl/bp_perf_sample_ctrl.sv
// Per-core measurement window controller: warmup, measure with periodic snapshots, final report.
module bp_perf_sample_ctrl #(
    parameter int cnt_width_p = 64,
    parameter int cfg_width_p = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   freeze_i,
    input  logic                   en_i,
    input  logic [cfg_width_p-1:0] warmup_instr_i,
    input  logic [cfg_width_p-1:0] measure_instr_i,
    input  logic [cfg_width_p-1:0] sample_period_i,
    input  logic                   stop_i,
    input  logic                   commit_v_i,
    input  logic                   is_debug_mode_i,
    input  logic                   dcache_access_v_i,
    input  logic                   dcache_hit_i,
    bp_perf_sample_ctrl_if.master  stream_if,
    output logic [2:0]             state_o,
    output logic [7:0]             drop_cnt_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        MEASURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e                 state_q;
    logic [cfg_width_p-1:0] warmup_q, limit_q, period_q;
    logic [cfg_width_p-1:0] warm_cnt_q, period_cnt_q;
    logic [cnt_width_p-1:0] clk_cnt_q, instr_cnt_q, acc_cnt_q, hit_cnt_q;
    logic [cnt_width_p-1:0] clk_cnt_d, instr_cnt_d, acc_cnt_d, hit_cnt_d;
    logic [cnt_width_p-1:0] shadow_q [4];
    logic [1:0]             word_q;
    logic                   v_q, final_q;
    logic [7:0]             drop_q;

    logic cnt_en, start, limit_hit, window_end, tick_raw, busy, last_xfer;

    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v, input logic inc);
        return (inc && !(&v)) ? v + cnt_width_p'(1) : v;
    endfunction

    assign cnt_en      = (state_q == MEASURE) && !is_debug_mode_i;
    assign clk_cnt_d   = sat_inc(clk_cnt_q,   cnt_en);
    assign instr_cnt_d = sat_inc(instr_cnt_q, cnt_en && commit_v_i);
    assign acc_cnt_d   = sat_inc(acc_cnt_q,   cnt_en && dcache_access_v_i);
    assign hit_cnt_d   = sat_inc(hit_cnt_q,   cnt_en && dcache_access_v_i && dcache_hit_i);

    assign start      = ((state_q == IDLE) || (state_q == DONE)) && en_i;
    assign limit_hit  = cnt_en && commit_v_i && (limit_q != '0)
                        && (instr_cnt_d == cnt_width_p'(limit_q));
    assign window_end = (state_q == MEASURE) && (stop_i || limit_hit);
    assign tick_raw   = cnt_en && (period_q != '0) && (period_cnt_q == period_q - cfg_width_p'(1));
    // A stream whose last word transfers this cycle is already free for a new capture.
    assign last_xfer  = v_q && stream_if.ready_i && (word_q == 2'd3);
    assign busy       = v_q && !last_xfer;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            warmup_q     <= '0;
            limit_q      <= '0;
            period_q     <= '0;
            warm_cnt_q   <= '0;
            period_cnt_q <= '0;
            clk_cnt_q    <= '0;
            instr_cnt_q  <= '0;
            acc_cnt_q    <= '0;
            hit_cnt_q    <= '0;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
            word_q       <= '0;
            v_q          <= 1'b0;
            final_q      <= 1'b0;
            drop_q       <= '0;
        end else if (freeze_i) begin
            state_q      <= IDLE;
            warm_cnt_q   <= '0;
            period_cnt_q <= '0;
            clk_cnt_q    <= '0;
            instr_cnt_q  <= '0;
            acc_cnt_q    <= '0;
            hit_cnt_q    <= '0;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
            word_q       <= '0;
            v_q          <= 1'b0;
            final_q      <= 1'b0;
            drop_q       <= '0;
        end else begin
            if (v_q && stream_if.ready_i) begin
                word_q <= word_q + 2'd1;
                if (word_q == 2'd3) v_q <= 1'b0;
            end

            if (start) begin
                state_q      <= WARMUP;
                warmup_q     <= warmup_instr_i;
                limit_q      <= measure_instr_i;
                period_q     <= sample_period_i;
                warm_cnt_q   <= '0;
                period_cnt_q <= '0;
                clk_cnt_q    <= '0;
                instr_cnt_q  <= '0;
                acc_cnt_q    <= '0;
                hit_cnt_q    <= '0;
                final_q      <= 1'b0;
                drop_q       <= '0;
            end else begin
                case (state_q)
                    WARMUP: begin
                        if (warm_cnt_q == warmup_q) state_q <= MEASURE;
                        else if (commit_v_i && !is_debug_mode_i) warm_cnt_q <= warm_cnt_q + cfg_width_p'(1);
                    end
                    MEASURE: begin
                        clk_cnt_q   <= clk_cnt_d;
                        instr_cnt_q <= instr_cnt_d;
                        acc_cnt_q   <= acc_cnt_d;
                        hit_cnt_q   <= hit_cnt_d;
                        if (cnt_en && period_q != '0)
                            period_cnt_q <= tick_raw ? '0 : period_cnt_q + cfg_width_p'(1);
                        // Window end wins over a coincident tick; only the final snapshot is sent.
                        if (window_end) begin
                            state_q <= DRAIN;
                        end else if (tick_raw) begin
                            if (busy) begin
                                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                            end else begin
                                shadow_q[0] <= clk_cnt_d;
                                shadow_q[1] <= instr_cnt_d;
                                shadow_q[2] <= acc_cnt_d;
                                shadow_q[3] <= hit_cnt_d;
                                v_q         <= 1'b1;
                                word_q      <= 2'd0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!final_q && !busy) begin
                            shadow_q[0] <= clk_cnt_q;
                            shadow_q[1] <= instr_cnt_q;
                            shadow_q[2] <= acc_cnt_q;
                            shadow_q[3] <= hit_cnt_q;
                            v_q         <= 1'b1;
                            word_q      <= 2'd0;
                            final_q     <= 1'b1;
                        end
                        if (final_q && last_xfer) state_q <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stream_if.data_o  = shadow_q[word_q];
    assign stream_if.v_o     = v_q;
    assign stream_if.last_o  = v_q && (word_q == 2'd3);
    assign stream_if.final_o = v_q && final_q;
    assign state_o           = state_q;
    assign drop_cnt_o        = drop_q;

endmodule
